// File: rtl/imem_arbiter_if.sv
// Bus bundle between the fetch stage, the load/store stage, the memory array
// and imem_arbiter. The arbiter takes the slave view; requesters/memory take master.
interface imem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              fe_req;
  logic [ADDR_W-1:0] fe_addr;
  logic              fe_gnt;
  logic              fe_rvalid;
  logic [DATA_W-1:0] fe_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              STALL;

  modport slave (
    input  fe_req, fe_addr, ls_req, ls_we, ls_addr, ls_wdata, ram_rdata,
    output fe_gnt, fe_rvalid, fe_rdata, ls_gnt, ls_rvalid, ls_rdata,
    output ram_addr, ram_we, ram_wdata, STALL
  );

  modport master (
    output fe_req, fe_addr, ls_req, ls_we, ls_addr, ls_wdata, ram_rdata,
    input  fe_gnt, fe_rvalid, fe_rdata, ls_gnt, ls_rvalid, ls_rdata,
    input  ram_addr, ram_we, ram_wdata, STALL
  );
endinterface

// File: rtl/imem_arbiter.sv
// Single-port memory arbiter: load/store beats fetch, reads return one cycle later.
// Define IMEM_ARB_FAIRNESS_EN to force a fetch grant after STARVE_MAX denied cycles.
module imem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input logic           CLOCK_50,
  input logic           reset,
  imem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FE_RD, LS_RD} ret_state_t;

  ret_state_t        state;
  ret_state_t        state_next;
  logic              fe_force;
  logic              fe_gnt;
  logic              ls_gnt;
  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_wdata;
  logic              mux_we;

`ifdef IMEM_ARB_FAIRNESS_EN
  logic [3:0] starve_cnt;

  assign fe_force = (starve_cnt == 4'(STARVE_MAX));

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!bus.fe_req || fe_gnt) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign fe_force = 1'b0;
`endif

  // Grants are gated by reset directly so nothing reaches the memory while it is held.
  always_comb begin
    ls_gnt = 1'b0;
    fe_gnt = 1'b0;
    if (!reset) begin
      ls_gnt = bus.ls_req && !(bus.fe_req && fe_force);
      fe_gnt = bus.fe_req && !ls_gnt;
    end
  end

  always_comb begin
    mux_addr  = '0;
    mux_wdata = '0;
    mux_we    = 1'b0;
    if (ls_gnt) begin
      mux_addr  = bus.ls_addr;
      mux_wdata = bus.ls_wdata;
      mux_we    = bus.ls_we;
    end else if (fe_gnt) begin
      mux_addr  = bus.fe_addr;
    end
  end

  // Return path: remembers who owns the data coming out of the memory next cycle.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = IDLE;
    if (fe_gnt) begin
      state_next = FE_RD;
    end else if (ls_gnt && !bus.ls_we) begin
      state_next = LS_RD;
    end
  end

  assign bus.fe_gnt    = fe_gnt;
  assign bus.ls_gnt    = ls_gnt;
  assign bus.ram_addr  = mux_addr;
  assign bus.ram_wdata = mux_wdata;
  assign bus.ram_we    = mux_we;
  assign bus.fe_rvalid = (state == FE_RD);
  assign bus.ls_rvalid = (state == LS_RD);
  assign bus.fe_rdata  = bus.ram_rdata;
  assign bus.ls_rdata  = bus.ram_rdata;
  assign bus.STALL     = bus.fe_req && !fe_gnt;

  // A pending load/store must not be withdrawn before it is granted.
  ls_req_held: assert property (
    @(posedge CLOCK_50) disable iff (reset) (bus.ls_req && !ls_gnt) |=> bus.ls_req
  );

  starve_max_range: assert property (
    @(posedge CLOCK_50) (STARVE_MAX >= 1) && (STARVE_MAX <= 15)
  );
endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios plus a randomized run against a
// cycle-level arbitration/memory reference model.
module tb_imem_arbiter;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int STARVE_MAX = 4;
`ifdef IMEM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic CLOCK_50 = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  logic [DATA_W-1:0] ram     [0:65535];
  logic [DATA_W-1:0] ref_mem [0:65535];

  imem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .bus(bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Synchronous-read memory array behind the arbiter.
  always @(posedge CLOCK_50) begin
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= ram[bus.ram_addr];
  end

  function automatic logic [DATA_W-1:0] init_val(int a);
    return DATA_W'((a * 37) ^ 16'h5A5A);
  endfunction

  task automatic next_cycle();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic idle_cycle();
    next_cycle();
    bus.fe_req = 1'b0;
    bus.ls_req = 1'b0;
    bus.ls_we  = 1'b0;
    @(negedge CLOCK_50);
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.fe_req   = 1'b1;
    bus.fe_addr  = 16'h0008;
    bus.ls_req   = 1'b0;
    bus.ls_we    = 1'b0;
    bus.ls_addr  = '0;
    bus.ls_wdata = '0;
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    checks++; if (bus.fe_gnt !== 1'b0) begin errors++; $display("FAIL rst_fe_gnt got=%b want=0", bus.fe_gnt); end
    checks++; if (bus.ls_gnt !== 1'b0) begin errors++; $display("FAIL rst_ls_gnt got=%b want=0", bus.ls_gnt); end
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we got=%b want=0", bus.ram_we); end
    checks++; if (bus.fe_rvalid !== 1'b0) begin errors++; $display("FAIL rst_fe_rvalid got=%b want=0", bus.fe_rvalid); end
    checks++; if (bus.ls_rvalid !== 1'b0) begin errors++; $display("FAIL rst_ls_rvalid got=%b want=0", bus.ls_rvalid); end
    checks++; if (bus.STALL !== 1'b1) begin errors++; $display("FAIL rst_stall got=%b want=1", bus.STALL); end
    checks++; if (bus.ram_addr !== 16'h0000) begin errors++; $display("FAIL rst_ram_addr got=%h want=0000", bus.ram_addr); end
  endtask

  task automatic test_reset_release_fetch();
    reset = 1'b0;
    #1;
    checks++; if (bus.fe_gnt !== 1'b1) begin errors++; $display("FAIL rel_fe_gnt got=%b want=1", bus.fe_gnt); end
    checks++; if (bus.ram_addr !== 16'h0008) begin errors++; $display("FAIL rel_ram_addr got=%h want=0008", bus.ram_addr); end
    checks++; if (bus.STALL !== 1'b0) begin errors++; $display("FAIL rel_stall got=%b want=0", bus.STALL); end
    @(negedge CLOCK_50);
    checks++; if (bus.fe_rvalid !== 1'b1) begin errors++; $display("FAIL rel_fe_rvalid got=%b want=1", bus.fe_rvalid); end
    checks++; if (bus.fe_rdata !== ref_mem[8]) begin errors++; $display("FAIL rel_fe_rdata got=%h want=%h", bus.fe_rdata, ref_mem[8]); end
    checks++; if (bus.ls_rvalid !== 1'b0) begin errors++; $display("FAIL rel_ls_rvalid got=%b want=0", bus.ls_rvalid); end
    idle_cycle();
    idle_cycle();
  endtask

  task automatic test_contention();
    next_cycle();
    bus.fe_req  = 1'b1;
    bus.fe_addr = 16'h0040;
    bus.ls_req  = 1'b1;
    bus.ls_we   = 1'b0;
    bus.ls_addr = 16'h0020;
    @(negedge CLOCK_50);
    checks++; if (bus.ls_gnt !== 1'b1) begin errors++; $display("FAIL cont_ls_gnt got=%b want=1", bus.ls_gnt); end
    checks++; if (bus.fe_gnt !== 1'b0) begin errors++; $display("FAIL cont_fe_gnt got=%b want=0", bus.fe_gnt); end
    checks++; if (bus.STALL !== 1'b1) begin errors++; $display("FAIL cont_stall got=%b want=1", bus.STALL); end
    checks++; if (bus.ram_addr !== 16'h0020) begin errors++; $display("FAIL cont_ram_addr got=%h want=0020", bus.ram_addr); end
    next_cycle();
    bus.ls_req = 1'b0;
    @(negedge CLOCK_50);
    checks++; if (bus.ls_rvalid !== 1'b1) begin errors++; $display("FAIL cont_ls_rvalid got=%b want=1", bus.ls_rvalid); end
    checks++; if (bus.ls_rdata !== ref_mem[16'h20]) begin errors++; $display("FAIL cont_ls_rdata got=%h want=%h", bus.ls_rdata, ref_mem[16'h20]); end
    checks++; if (bus.fe_gnt !== 1'b1) begin errors++; $display("FAIL cont_fe_after got=%b want=1", bus.fe_gnt); end
    checks++; if (bus.ram_addr !== 16'h0040) begin errors++; $display("FAIL cont_fe_addr got=%h want=0040", bus.ram_addr); end
    next_cycle();
    bus.fe_req = 1'b0;
    @(negedge CLOCK_50);
    checks++; if (bus.fe_rvalid !== 1'b1) begin errors++; $display("FAIL cont_fe_rvalid got=%b want=1", bus.fe_rvalid); end
    checks++; if (bus.fe_rdata !== ref_mem[16'h40]) begin errors++; $display("FAIL cont_fe_rdata got=%h want=%h", bus.fe_rdata, ref_mem[16'h40]); end
    checks++; if (bus.ls_rvalid !== 1'b0) begin errors++; $display("FAIL cont_ls_rvalid2 got=%b want=0", bus.ls_rvalid); end
    idle_cycle();
  endtask

  task automatic test_store();
    next_cycle();
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b1;
    bus.ls_addr  = 16'h0030;
    bus.ls_wdata = 16'hBEEF;
    @(negedge CLOCK_50);
    checks++; if (bus.ram_we !== 1'b1) begin errors++; $display("FAIL st_ram_we got=%b want=1", bus.ram_we); end
    checks++; if (bus.ram_wdata !== 16'hBEEF) begin errors++; $display("FAIL st_wdata got=%h want=beef", bus.ram_wdata); end
    checks++; if (bus.ram_addr !== 16'h0030) begin errors++; $display("FAIL st_addr got=%h want=0030", bus.ram_addr); end
    ref_mem[16'h30] = 16'hBEEF;
    next_cycle();
    bus.ls_req  = 1'b0;
    bus.ls_we   = 1'b0;
    bus.fe_req  = 1'b1;
    bus.fe_addr = 16'h0030;
    @(negedge CLOCK_50);
    checks++; if (bus.ls_rvalid !== 1'b0) begin errors++; $display("FAIL st_ls_rvalid got=%b want=0", bus.ls_rvalid); end
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL st_we_one_cycle got=%b want=0", bus.ram_we); end
    checks++; if (bus.fe_gnt !== 1'b1) begin errors++; $display("FAIL st_fe_gnt got=%b want=1", bus.fe_gnt); end
    next_cycle();
    bus.fe_req = 1'b0;
    @(negedge CLOCK_50);
    checks++; if (bus.fe_rvalid !== 1'b1) begin errors++; $display("FAIL st_fe_rvalid got=%b want=1", bus.fe_rvalid); end
    checks++; if (bus.fe_rdata !== 16'hBEEF) begin errors++; $display("FAIL st_readback got=%h want=beef", bus.fe_rdata); end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    next_cycle();
    bus.fe_req  = 1'b1;
    bus.fe_addr = 16'h0011;
    @(negedge CLOCK_50);
    next_cycle();
    bus.fe_addr = 16'h0012;
    @(negedge CLOCK_50);
    checks++; if (bus.fe_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_rv1 got=%b want=1", bus.fe_rvalid); end
    checks++; if (bus.fe_rdata !== ref_mem[16'h11]) begin errors++; $display("FAIL b2b_d1 got=%h want=%h", bus.fe_rdata, ref_mem[16'h11]); end
    next_cycle();
    bus.fe_req  = 1'b0;
    bus.ls_req  = 1'b1;
    bus.ls_we   = 1'b0;
    bus.ls_addr = 16'h0013;
    @(negedge CLOCK_50);
    checks++; if (bus.ls_gnt !== 1'b1) begin errors++; $display("FAIL b2b_ls_gnt got=%b want=1", bus.ls_gnt); end
    checks++; if (bus.fe_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_rv2 got=%b want=1", bus.fe_rvalid); end
    checks++; if (bus.fe_rdata !== ref_mem[16'h12]) begin errors++; $display("FAIL b2b_d2 got=%h want=%h", bus.fe_rdata, ref_mem[16'h12]); end
    next_cycle();
    bus.ls_req = 1'b0;
    @(negedge CLOCK_50);
    checks++; if (bus.ls_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_ls_rv got=%b want=1", bus.ls_rvalid); end
    checks++; if (bus.ls_rdata !== ref_mem[16'h13]) begin errors++; $display("FAIL b2b_ls_d got=%h want=%h", bus.ls_rdata, ref_mem[16'h13]); end
    checks++; if (bus.fe_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_fe_rv_end got=%b want=0", bus.fe_rvalid); end
    idle_cycle();
  endtask

  task automatic test_starvation();
    logic exp_fe;
    idle_cycle();
    for (int i = 0; i < 14; i++) begin
      next_cycle();
      bus.fe_req  = 1'b1;
      bus.fe_addr = 16'h0050;
      bus.ls_req  = 1'b1;
      bus.ls_we   = 1'b0;
      bus.ls_addr = 16'h0060;
      @(negedge CLOCK_50);
      exp_fe = FAIR && ((i % (STARVE_MAX + 1)) == STARVE_MAX);
      checks++; if (bus.fe_gnt !== exp_fe) begin errors++; $display("FAIL starve_fe_gnt[%0d] got=%b want=%b", i, bus.fe_gnt, exp_fe); end
      checks++; if (bus.ls_gnt !== !exp_fe) begin errors++; $display("FAIL starve_ls_gnt[%0d] got=%b want=%b", i, bus.ls_gnt, !exp_fe); end
      checks++; if (bus.STALL !== !exp_fe) begin errors++; $display("FAIL starve_stall[%0d] got=%b want=%b", i, bus.STALL, !exp_fe); end
    end
    idle_cycle();
  endtask

  task automatic test_reset_mid_read();
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      bus.fe_req  = 1'b1;
      bus.fe_addr = 16'h0005;
      bus.ls_req  = 1'b1;
      bus.ls_we   = 1'b0;
      bus.ls_addr = 16'h0006;
    end
    next_cycle();
    bus.ls_req = 1'b0;
    @(negedge CLOCK_50);
    checks++; if (bus.fe_gnt !== 1'b1) begin errors++; $display("FAIL mid_fe_gnt got=%b want=1", bus.fe_gnt); end
`ifdef IMEM_ARB_FAIRNESS_EN
    checks++; if (dut.starve_cnt !== 4'd2) begin errors++; $display("FAIL mid_cnt_pre got=%0d want=2", dut.starve_cnt); end
`endif
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.fe_rvalid !== 1'b0) begin errors++; $display("FAIL mid_fe_rvalid got=%b want=0", bus.fe_rvalid); end
    checks++; if (bus.ls_rvalid !== 1'b0) begin errors++; $display("FAIL mid_ls_rvalid got=%b want=0", bus.ls_rvalid); end
    checks++; if (bus.fe_gnt !== 1'b0) begin errors++; $display("FAIL mid_gnt got=%b want=0", bus.fe_gnt); end
    checks++; if (bus.STALL !== 1'b1) begin errors++; $display("FAIL mid_stall got=%b want=1", bus.STALL); end
`ifdef IMEM_ARB_FAIRNESS_EN
    checks++; if (dut.starve_cnt !== 4'd0) begin errors++; $display("FAIL mid_cnt_rst got=%0d want=0", dut.starve_cnt); end
`endif
    next_cycle();
    checks++; if (bus.fe_rvalid !== 1'b0) begin errors++; $display("FAIL mid_fe_rvalid_edge got=%b want=0", bus.fe_rvalid); end
    bus.fe_req = 1'b0;
    #2;
    reset = 1'b0;
    next_cycle();
    checks++; if (bus.fe_rvalid !== 1'b0) begin errors++; $display("FAIL mid_no_reissue got=%b want=0", bus.fe_rvalid); end
    idle_cycle();
  endtask

  task automatic test_random();
    logic              e_fe, e_ls, force_fe, ls_hold;
    logic              exp_fe_rv, exp_ls_rv;
    logic [DATA_W-1:0] exp_fe_d, exp_ls_d, exp_wd;
    logic [ADDR_W-1:0] exp_addr;
    int                streak;
    idle_cycle();
    idle_cycle();
    exp_fe_rv = 1'b0;
    exp_ls_rv = 1'b0;
    exp_fe_d  = '0;
    exp_ls_d  = '0;
    streak    = 0;
    ls_hold   = 1'b0;
    for (int n = 0; n < 400; n++) begin
      next_cycle();
      if (!ls_hold) begin
        bus.ls_req   = ($urandom_range(0, 2) != 0);
        bus.ls_we    = ($urandom_range(0, 3) == 0);
        bus.ls_addr  = ADDR_W'($urandom_range(0, 31));
        bus.ls_wdata = DATA_W'($urandom);
      end
      bus.fe_req  = ($urandom_range(0, 3) != 0);
      bus.fe_addr = ADDR_W'($urandom_range(0, 31));
      @(negedge CLOCK_50);
      // Load/store wins unless fetch has waited STARVE_MAX cycles in a row.
      force_fe = FAIR && bus.fe_req && (streak == STARVE_MAX);
      e_ls     = bus.ls_req && !force_fe;
      e_fe     = bus.fe_req && !e_ls;
      exp_addr = e_ls ? bus.ls_addr : (e_fe ? bus.fe_addr : '0);
      exp_wd   = bus.ls_wdata;
      checks++; if (bus.fe_gnt !== e_fe) begin errors++; $display("FAIL rnd_fe_gnt[%0d] got=%b want=%b", n, bus.fe_gnt, e_fe); end
      checks++; if (bus.ls_gnt !== e_ls) begin errors++; $display("FAIL rnd_ls_gnt[%0d] got=%b want=%b", n, bus.ls_gnt, e_ls); end
      checks++; if (bus.STALL !== (bus.fe_req && !e_fe)) begin errors++; $display("FAIL rnd_stall[%0d] got=%b want=%b", n, bus.STALL, bus.fe_req && !e_fe); end
      checks++; if (bus.ram_addr !== exp_addr) begin errors++; $display("FAIL rnd_addr[%0d] got=%h want=%h", n, bus.ram_addr, exp_addr); end
      checks++; if (bus.ram_we !== (e_ls && bus.ls_we)) begin errors++; $display("FAIL rnd_we[%0d] got=%b want=%b", n, bus.ram_we, e_ls && bus.ls_we); end
      if (e_ls && bus.ls_we) begin
        checks++; if (bus.ram_wdata !== exp_wd) begin errors++; $display("FAIL rnd_wdata[%0d] got=%h want=%h", n, bus.ram_wdata, exp_wd); end
      end
      checks++; if (bus.fe_rvalid !== exp_fe_rv) begin errors++; $display("FAIL rnd_fe_rv[%0d] got=%b want=%b", n, bus.fe_rvalid, exp_fe_rv); end
      checks++; if (bus.ls_rvalid !== exp_ls_rv) begin errors++; $display("FAIL rnd_ls_rv[%0d] got=%b want=%b", n, bus.ls_rvalid, exp_ls_rv); end
      if (exp_fe_rv) begin
        checks++; if (bus.fe_rdata !== exp_fe_d) begin errors++; $display("FAIL rnd_fe_d[%0d] got=%h want=%h", n, bus.fe_rdata, exp_fe_d); end
      end
      if (exp_ls_rv) begin
        checks++; if (bus.ls_rdata !== exp_ls_d) begin errors++; $display("FAIL rnd_ls_d[%0d] got=%h want=%h", n, bus.ls_rdata, exp_ls_d); end
      end
      exp_fe_rv = e_fe;
      exp_fe_d  = ref_mem[bus.fe_addr];
      exp_ls_rv = e_ls && !bus.ls_we;
      exp_ls_d  = ref_mem[bus.ls_addr];
      if (e_ls && bus.ls_we) ref_mem[bus.ls_addr] = bus.ls_wdata;
      streak  = (bus.fe_req && !e_fe) ? streak + 1 : 0;
      ls_hold = bus.ls_req && !e_ls;
    end
    next_cycle();
    bus.fe_req = 1'b0;
    next_cycle();
    bus.ls_req = 1'b0;
    @(negedge CLOCK_50);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin
      ram[a]     = init_val(a);
      ref_mem[a] = init_val(a);
    end
    test_reset();
    test_reset_release_fetch();
    test_contention();
    test_store();
    test_back_to_back();
    test_starvation();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
